// File: rtl/cheriot_mem_model.sv
// Single-port word memory on an Ibex/CHERIoT-style req/gnt/rvalid bus, with
// LFSR-driven grant and response wait states that replay identically after every reset.
module cheriot_mem_model #(
  parameter int          MEM_AW    = 14,
  parameter int          MEM_DW    = 32,
  parameter int          GNT_WMAX  = 2,
  parameter int          RESP_WMAX = 2,
  parameter logic [31:0] MEM_BASE  = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [3:0]        data_be,
  input  logic [31:0]       data_addr,
  input  logic [MEM_DW-1:0] data_wdata,
  output logic              data_gnt,
  output logic              data_rvalid,
  output logic [MEM_DW-1:0] data_rdata,
  output logic              data_err
);

  // Handshake: a request is accepted in the cycle where data_req and data_gnt are both
  // high; data_req must stay high until then. Each accepted request produces exactly one
  // single-cycle data_rvalid later, strictly in request order.

  localparam int DEPTH = 2 ** MEM_AW;
  localparam int QD    = 4;
  localparam int GCW   = (GNT_WMAX > 0) ? $clog2(GNT_WMAX + 1) : 1;
  localparam int RCW   = (RESP_WMAX > 0) ? $clog2(RESP_WMAX + 1) : 1;

  typedef enum logic {G_IDLE, G_WAIT} gstate_e;

  typedef struct packed {
    logic [MEM_DW-1:0] rdata;
    logic              err;
    logic [RCW-1:0]    cnt;
  } rsp_t;

  logic [15:0]       lfsr_q, lfsr_d;
  logic [15:0]       gnt_draw16, resp_draw16;
  logic [GCW-1:0]    gnt_draw;
  logic [RCW-1:0]    resp_draw;
  gstate_e           gstate_q, gstate_d;
  logic [GCW-1:0]    wait_q, wait_d, wait_eff;
  logic [31:0]       offset;
  logic              in_range;
  logic [MEM_AW-1:0] widx;
  logic [MEM_DW-1:0] mem_q [DEPTH];
  logic [MEM_DW-1:0] rd_word, wr_mask, mem_word_d;
  logic [31:0]       be_mask;
  logic              mem_we;
  rsp_t              q_q [QD];
  rsp_t              q_d [QD];
  logic [1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [MEM_DW-1:0] rdata_q, rdata_d;
  logic              q_full, push, pop;
  logic              unused_bits;

  // Fibonacci LFSR, taps 16,14,13,11; one value feeds both wait draws each cycle.
  always_comb begin
    lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    gnt_draw16  = lfsr_q % 16'(GNT_WMAX + 1);
    resp_draw16 = {8'h00, lfsr_q[15:8]} % 16'(RESP_WMAX + 1);
    gnt_draw    = gnt_draw16[GCW-1:0];
    resp_draw   = resp_draw16[RCW-1:0];
  end

  // A fresh wait is drawn on the first cycle of every request, so a zero draw grants at once.
  always_comb begin
    gstate_d = gstate_q;
    wait_d   = wait_q;
    data_gnt = 1'b0;
    wait_eff = (gstate_q == G_WAIT) ? wait_q : gnt_draw;
    if (!data_req) begin
      gstate_d = G_IDLE;
      wait_d   = '0;
    end else if (wait_eff == '0 && !q_full) begin
      data_gnt = 1'b1;
      gstate_d = G_IDLE;
      wait_d   = '0;
    end else begin
      gstate_d = G_WAIT;
      wait_d   = (wait_eff == '0) ? '0 : wait_eff - GCW'(1);
    end
  end

  always_comb begin
    offset   = data_addr - MEM_BASE;
    in_range = (offset[31:MEM_AW+2] == '0);
    widx     = offset[MEM_AW+1:2];
  end

  assign be_mask = {{8{data_be[3]}}, {8{data_be[2]}}, {8{data_be[1]}}, {8{data_be[0]}}};

  // Meta bits above 31 follow any write that enables at least one byte.
  generate
    if (MEM_DW > 32) begin : g_meta
      assign wr_mask = {{(MEM_DW - 32){|data_be}}, be_mask};
    end else begin : g_plain
      assign wr_mask = be_mask[MEM_DW-1:0];
    end
  endgenerate

  assign rd_word    = mem_q[widx];
  assign mem_word_d = (rd_word & ~wr_mask) | (data_wdata & wr_mask);
  assign mem_we     = data_gnt & data_we & in_range;

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[widx] <= mem_word_d;
  end

  // Every entry counts down in place; only the head may retire, which keeps order.
  assign q_full = (cnt_q == 3'd4);
  assign pop    = (cnt_q != 3'd0) && (q_q[rd_ptr_q].cnt == '0);
  assign push   = data_gnt;

  always_comb begin
    for (int i = 0; i < QD; i++) begin
      q_d[i] = q_q[i];
      if (q_q[i].cnt != '0) q_d[i].cnt = q_q[i].cnt - RCW'(1);
    end
    if (push) begin
      q_d[wr_ptr_q].rdata = (data_we || !in_range) ? '0 : rd_word;
      q_d[wr_ptr_q].err   = !in_range;
      q_d[wr_ptr_q].cnt   = resp_draw;
    end
    wr_ptr_d = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 2'd1 : rd_ptr_q;
    cnt_d    = cnt_q + 3'(push) - 3'(pop);
    rdata_d  = pop ? q_q[rd_ptr_q].rdata : rdata_q;
  end

  assign data_rvalid = pop;
  assign data_rdata  = pop ? q_q[rd_ptr_q].rdata : rdata_q;
  assign data_err    = pop & q_q[rd_ptr_q].err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q   <= 16'hACE1;
      gstate_q <= G_IDLE;
      wait_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      for (int i = 0; i < QD; i++) q_q[i] <= '0;
    end else begin
      lfsr_q   <= lfsr_d;
      gstate_q <= gstate_d;
      wait_q   <= wait_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      for (int i = 0; i < QD; i++) q_q[i] <= q_d[i];
    end
  end

  assign unused_bits = ^{offset[1:0], gnt_draw16[15:GCW], resp_draw16[15:RCW]};

endmodule

// File: tb/tb_cheriot_mem_model.sv
// Bench for cheriot_mem_model: cycle-level reference model of grant/response timing and
// memory contents, plus literal checks on a zero-wait instance and on tag handling.
module tb_cheriot_mem_model;

  localparam int          DW   = 33;
  localparam int          GW   = 2;
  localparam int          RW   = 2;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          data_req = 1'b0, data_we = 1'b0;
  logic [3:0]    data_be = 4'h0;
  logic [31:0]   data_addr = 32'h0;
  logic [DW-1:0] data_wdata = '0;
  logic          data_gnt, data_rvalid, data_err;
  logic [DW-1:0] data_rdata;

  logic          f_req = 1'b0, f_we = 1'b0;
  logic [3:0]    f_be = 4'h0;
  logic [31:0]   f_addr = 32'h0, f_wdata = 32'h0;
  logic          f_gnt, f_rvalid, f_err;
  logic [31:0]   f_rdata;

  int n_vec = 0;
  int n_fail = 0;

  cheriot_mem_model #(.MEM_AW(14), .MEM_DW(DW), .GNT_WMAX(GW), .RESP_WMAX(RW),
                      .MEM_BASE(BASE)) u_dut (
    .clk(clk), .rst_n(rst_n), .data_req(data_req), .data_we(data_we), .data_be(data_be),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_gnt(data_gnt),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata), .data_err(data_err));

  cheriot_mem_model #(.MEM_AW(14), .MEM_DW(32), .GNT_WMAX(0), .RESP_WMAX(0),
                      .MEM_BASE(BASE)) u_fast (
    .clk(clk), .rst_n(rst_n), .data_req(f_req), .data_we(f_we), .data_be(f_be),
    .data_addr(f_addr), .data_wdata(f_wdata), .data_gnt(f_gnt),
    .data_rvalid(f_rvalid), .data_rdata(f_rdata), .data_err(f_err));

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + compare ----------------
  typedef struct {
    logic [DW-1:0] d;
    logic          e;
    int            due;
  } ent_t;

  ent_t          exp_q[$];
  logic [DW:0]   obs_q[$];
  logic [DW-1:0] mm [int];
  logic [15:0]   m_lfsr = 16'hACE1;
  int            cyc = 0;
  bit            m_active = 0;
  int            m_start = 0, m_n = 0;
  logic [DW-1:0] m_hold = '0;
  int            gnt_cnt = 0, rv_cnt = 0, max_out = 0;
  logic          e_gnt, e_rv, fb;
  ent_t          m_ent;
  logic [31:0]   m_off;
  int            m_idx;
  logic [DW-1:0] m_cur;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_gnt", data_gnt, 0);
      chk("rst_rvalid", data_rvalid, 0);
      chk("rst_rdata", data_rdata, 0);
      chk("rst_err", data_err, 0);
      exp_q.delete();
      obs_q.delete();
      m_lfsr   = 16'hACE1;
      m_active = 0;
      m_hold   = '0;
      gnt_cnt  = 0;
      rv_cnt   = 0;
    end else begin
      if (!data_req) m_active = 0;
      else if (!m_active) begin
        m_active = 1;
        m_start  = cyc;
        m_n      = int'(m_lfsr) % (GW + 1);
      end
      e_gnt = data_req && (cyc - m_start >= m_n) && (exp_q.size() < 4);
      e_rv  = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
      chk("gnt", data_gnt, e_gnt);
      chk("rvalid", data_rvalid, e_rv);
      if (e_rv) begin
        chk("rdata", data_rdata, exp_q[0].d);
        chk("err", data_err, exp_q[0].e);
        m_hold = exp_q[0].d;
        void'(exp_q.pop_front());
      end else begin
        chk("rdata_hold", data_rdata, m_hold);
      end
      if (data_rvalid) begin
        obs_q.push_back({data_err, data_rdata});
        rv_cnt++;
      end
      if (data_gnt) gnt_cnt++;
      if (gnt_cnt - rv_cnt > max_out) max_out = gnt_cnt - rv_cnt;
      if (e_gnt) begin
        m_off   = data_addr - BASE;
        m_ent.e = (m_off >= 32'h0001_0000);
        m_ent.d = '0;
        if (!m_ent.e) begin
          m_idx = int'(m_off >> 2);
          m_cur = mm.exists(m_idx) ? mm[m_idx] : '0;
          if (!data_we) m_ent.d = m_cur;
          else begin
            for (int b = 0; b < 4; b++)
              if (data_be[b]) m_cur[8*b +: 8] = data_wdata[8*b +: 8];
            if (data_be != 4'h0) m_cur[32] = data_wdata[32];
            mm[m_idx] = m_cur;
          end
        end
        m_ent.due = cyc + 1 + int'(m_lfsr[15:8]) % (RW + 1);
        exp_q.push_back(m_ent);
        m_active = 0;
      end
      fb     = m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10];
      m_lfsr = {m_lfsr[14:0], fb};
      cyc++;
    end
  end

  // ---------------- driver tasks (entered and left at posedge+1) ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [DW-1:0] wd);
    int b;
    data_req   = 1'b1;
    data_we    = we;
    data_be    = be;
    data_addr  = addr;
    data_wdata = wd;
    b = 0;
    @(negedge clk);
    while (!data_gnt && b < 20) begin
      @(negedge clk);
      b++;
    end
    if (!data_gnt) chk("gnt_timeout", 0, 1);
    @(posedge clk);
    #1;
    data_req = 1'b0;
  endtask

  task automatic get_resp(output logic [DW-1:0] d, output logic e);
    int b;
    b = 0;
    while (obs_q.size() == 0 && b < 30) begin
      @(posedge clk);
      b++;
    end
    #1;
    if (obs_q.size() == 0) begin
      chk("resp_timeout", 0, 1);
      d = '0;
      e = 1'b0;
    end else begin
      {e, d} = obs_q.pop_front();
    end
  endtask

  task automatic xact(input logic we, input logic [3:0] be, input logic [31:0] addr,
                      input logic [DW-1:0] wd, output logic [DW-1:0] d, output logic e);
    issue(we, be, addr, wd);
    get_resp(d, e);
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 50) begin
      @(posedge clk);
      b++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 0, 1);
    idle(2);
    obs_q.delete();
  endtask

  task automatic gap();
    if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
  endtask

  // ---------------- stimulus ----------------
  logic [DW-1:0] rd;
  logic          re;
  logic [31:0]   ra;

  initial begin
    idle(3);
    rst_n = 1'b1;
    idle(1);

    // Zero-wait instance: same-cycle grant, response exactly one cycle later.
    f_req = 1'b1; f_we = 1'b1; f_be = 4'hF; f_addr = BASE + 32'h10; f_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("fast_wr_gnt", f_gnt, 1);
    chk("fast_wr_rvalid_early", f_rvalid, 0);
    @(posedge clk); #1; f_req = 1'b0;
    @(negedge clk);
    chk("fast_wr_rvalid", f_rvalid, 1);
    chk("fast_wr_rdata", f_rdata, 0);
    @(posedge clk); #1; f_req = 1'b1; f_we = 1'b0;
    @(negedge clk);
    chk("fast_rd_gnt", f_gnt, 1);
    chk("fast_rd_rvalid_early", f_rvalid, 0);
    @(posedge clk); #1; f_req = 1'b0;
    @(negedge clk);
    chk("fast_rd_rvalid", f_rvalid, 1);
    chk("fast_rd_rdata", f_rdata, 32'hDEAD_BEEF);
    chk("fast_rd_err", f_err, 0);
    @(negedge clk);
    chk("fast_rvalid_pulse", f_rvalid, 0);
    chk("fast_rdata_hold", f_rdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;

    // Byte-enable merge and tag bit.
    drain();
    xact(1, 4'hF, BASE + 32'h100, 33'h1_FFFF_FFFF, rd, re);
    xact(1, 4'b0101, BASE + 32'h100, 33'h0_1122_3344, rd, re);
    chk("wr_rsp_rdata", rd, 0);
    xact(0, 4'hF, BASE + 32'h100, '0, rd, re);
    chk("be_merge", rd, 33'h0_FF22_FF44);
    chk("be_merge_err", re, 0);
    xact(1, 4'hF, BASE + 32'h200, 33'h1_1234_5678, rd, re);
    xact(0, 4'hF, BASE + 32'h200, '0, rd, re);
    chk("tag_set", rd, 33'h1_1234_5678);
    xact(1, 4'b0001, BASE + 32'h200, 33'h0_0000_00AA, rd, re);
    xact(0, 4'hF, BASE + 32'h202, '0, rd, re);
    chk("tag_clear", rd, 33'h0_1234_56AA);

    // Out-of-range accesses.
    xact(1, 4'hF, BASE, 33'h0_CAFE_F00D, rd, re);
    xact(1, 4'hF, 32'h8001_0000, 33'h1_FFFF_FFFF, rd, re);
    chk("oob_wr_err", re, 1);
    chk("oob_wr_rdata", rd, 0);
    xact(0, 4'hF, 32'h8001_0000, '0, rd, re);
    chk("oob_rd_err", re, 1);
    chk("oob_rd_rdata", rd, 0);
    xact(0, 4'hF, 32'h7FFF_FFFC, '0, rd, re);
    chk("below_base_err", re, 1);
    xact(0, 4'hF, BASE, '0, rd, re);
    chk("oob_no_alias", rd, 33'h0_CAFE_F00D);
    chk("oob_no_alias_err", re, 0);

    // Fill a 64-word window, then random traffic with default waits.
    for (int i = 0; i < 64; i++) begin
      issue(1, 4'hF, BASE + 32'(i * 4), {1'($urandom_range(0, 1)), 32'($urandom())});
      gap();
    end
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 19) == 0)
        ra = ($urandom_range(0, 1) == 0) ? BASE + 32'h0001_0000 + 32'($urandom_range(0, 255) * 4)
                                         : BASE - 32'd4;
      else
        ra = BASE + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
      issue(0, 4'($urandom_range(0, 15)), ra, '0);
      gap();
    end
    for (int i = 0; i < 300; i++) begin
      issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            BASE + 32'($urandom_range(0, 63) * 4), {1'($urandom_range(0, 1)), 32'($urandom())});
      gap();
    end
    drain();
    chk("gnt_eq_rvalid", rv_cnt, gnt_cnt);
    chk("max_outstanding_le4", (max_out <= 4), 1);

    // Reset with responses in flight: nothing stale afterwards, memory kept.
    for (int i = 0; i < 50; i++) begin
      issue(0, 4'hF, BASE + 32'($urandom_range(0, 63) * 4), '0);
      if (exp_q.size() >= 3) break;
    end
    rst_n = 1'b0;
    #1;
    chk("rst_rvalid_now", data_rvalid, 0);
    idle(2);
    rst_n = 1'b1;
    idle(6);
    xact(0, 4'hF, BASE + 32'h100, '0, rd, re);
    chk("mem_kept_after_rst", rd, 33'h0_FF22_FF44);
    for (int i = 0; i < 16; i++) begin
      issue(0, 4'hF, BASE + 32'(i * 4), '0);
      gap();
    end
    drain();
    chk("gnt_eq_rvalid_after_rst", rv_cnt, gnt_cnt);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
